// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI DRAM read slave.
package axi_rd_pkg;

    localparam int unsigned BEAT_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
        logic [1:0]             resp;
    } rd_beat_t;

endpackage

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry beat FIFO between the DRAM read return and the R channel.
module axi_rd_skid_fifo
    import axi_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  rd_beat_t   din,
    output rd_beat_t   dout,
    output logic [1:0] cnt
);

    rd_beat_t   mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem_q[rd_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/axi_dram_rd_slv.sv
// AXI-style multi-burst read slave over the on-chip DRAM word array.
// Optional address range check enabled by defining AXI_RD_ADDR_CHK_EN.
module axi_dram_rd_slv
    import axi_rd_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   lsu_axi_arid,
    input  logic [ADDR_W-1:0] lsu_axi_araddr,
    input  logic [7:0]        lsu_axi_arlen,
    input  logic [2:0]        lsu_axi_arsize,
    input  logic [1:0]        lsu_axi_arburst,
    input  logic [2:0]        lsu_axi_arstr,
    input  logic [7:0]        lsu_axi_arnum,
    input  logic              lsu_axi_arvld,
    output logic              axi_lsu_arrdy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ID_W-1:0]   axi_lsu_rid,
    output logic [DATA_W-1:0] axi_lsu_rdata,
    output logic [1:0]        axi_lsu_rresp,
    output logic              axi_lsu_rlast,
    output logic              axi_lsu_rvld,
    input  logic              lsu_axi_rrdy
);

    rd_state_e         state_q, state_d;
    logic              arrdy_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        len_q;
    logic [7:0]        num_q;
    logic [2:0]        str_q;
    logic              fixed_q;
    logic              err_q;
    logic [7:0]        beat_q;
    logic [7:0]        bst_q;
    logic              inflight_q;
    logic              inf_last_q;
    logic              inf_rerr_q;

    logic              ar_hs_c;
    logic              issue_c;
    logic              pop_c;
    logic              last_beat_c;
    logic              last_burst_c;
    logic              credit_ok_c;
    logic              drain_done_c;
    logic              rerr_c;
    logic [1:0]        occ_c;
    logic [1:0]        fifo_cnt;
    logic [15:0]       stride_c;
    logic [ADDR_W-1:0] addr_c;
    rd_beat_t          beat_in;
    rd_beat_t          head;

    assign ar_hs_c      = lsu_axi_arvld & arrdy_q;
    assign last_beat_c  = (beat_q == len_q);
    assign last_burst_c = (bst_q == num_q);
    assign pop_c        = axi_lsu_rvld & lsu_axi_rrdy;

    // Credit counts the slot freed by a same-cycle pop so rrdy=1 streams without bubbles.
    assign occ_c        = fifo_cnt - {1'b0, pop_c} + {1'b0, inflight_q};
    assign credit_ok_c  = (occ_c < 2'd2);
    assign drain_done_c = !inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop_c));

    assign stride_c = (16'(len_q) + 16'd1) << str_q;
    assign addr_c   = base_q + (fixed_q ? '0 : ADDR_W'(beat_q));

`ifdef AXI_RD_ADDR_CHK_EN
    assign rerr_c    = (32'(addr_c) >= 32'(MEM_WORDS));
    assign mem_rd_en = issue_c & ~rerr_c;
`else
    assign rerr_c    = 1'b0;
    assign mem_rd_en = issue_c;
`endif
    assign mem_rd_addr = mem_rd_en ? addr_c : '0;

    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (credit_ok_c) begin
                    issue_c = 1'b1;
                    if (last_beat_c && last_burst_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            arrdy_q <= 1'b1;
        end else begin
            state_q <= state_d;
            arrdy_q <= (state_d == IDLE);
        end
    end

    // Request capture and burst/beat address generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            base_q  <= '0;
            len_q   <= 8'd0;
            num_q   <= 8'd0;
            str_q   <= 3'd0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= 8'd0;
            bst_q   <= 8'd0;
        end else if (ar_hs_c) begin
            id_q    <= lsu_axi_arid;
            base_q  <= lsu_axi_araddr;
            len_q   <= lsu_axi_arlen;
            num_q   <= lsu_axi_arnum;
            str_q   <= lsu_axi_arstr;
            fixed_q <= (lsu_axi_arburst == BURST_FIXED);
            err_q   <= (lsu_axi_arburst != BURST_FIXED) && (lsu_axi_arburst != BURST_INCR);
            beat_q  <= 8'd0;
            bst_q   <= 8'd0;
        end else if (issue_c) begin
            if (last_beat_c) begin
                beat_q <= 8'd0;
                bst_q  <= bst_q + 8'd1;
                base_q <= base_q + ADDR_W'(stride_c);
            end else begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    // One-cycle array read pipeline stage carrying the beat's metadata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            inf_last_q <= 1'b0;
            inf_rerr_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            inf_last_q <= last_beat_c;
            inf_rerr_q <= rerr_c;
        end
    end

    assign beat_in.data = inf_rerr_q ? '0 : BEAT_DATA_W'(mem_rd_data);
    assign beat_in.last = inf_last_q;
    assign beat_in.resp = (err_q | inf_rerr_q) ? RESP_SLVERR : RESP_OKAY;

    axi_rd_skid_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop_c),
        .din   (beat_in),
        .dout  (head),
        .cnt   (fifo_cnt)
    );

    assign axi_lsu_arrdy = arrdy_q;
    assign axi_lsu_rvld  = (fifo_cnt != 2'd0);
    assign axi_lsu_rid   = id_q;
    assign axi_lsu_rdata = DATA_W'(head.data);
    assign axi_lsu_rresp = head.resp;
    assign axi_lsu_rlast = head.last;

    logic unused_c;
    assign unused_c = ^{lsu_axi_arsize, 32'(MEM_WORDS)};

endmodule

// File: tb/tb_axi_dram_rd_slv.sv
// Scoreboard bench for axi_dram_rd_slv: expected addresses and beats queued at request time.
module tb_axi_dram_rd_slv;

`ifdef AXI_RD_ADDR_CHK_EN
    localparam int unsigned MEMW = 512;
`else
    localparam int unsigned MEMW = 1024;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  arid;
    logic [9:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arstr;
    logic [7:0]  arnum;
    logic        arvld;
    logic        arrdy;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvld;
    logic        rrdy;

    axi_dram_rd_slv #(.ADDR_W(10), .DATA_W(64), .ID_W(8), .MEM_WORDS(MEMW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_axi_arid    (arid),
        .lsu_axi_araddr  (araddr),
        .lsu_axi_arlen   (arlen),
        .lsu_axi_arsize  (arsize),
        .lsu_axi_arburst (arburst),
        .lsu_axi_arstr   (arstr),
        .lsu_axi_arnum   (arnum),
        .lsu_axi_arvld   (arvld),
        .axi_lsu_arrdy   (arrdy),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .axi_lsu_rid     (rid),
        .axi_lsu_rdata   (rdata),
        .axi_lsu_rresp   (rresp),
        .axi_lsu_rlast   (rlast),
        .axi_lsu_rvld    (rvld),
        .lsu_axi_rrdy    (rrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } exp_beat_t;

    exp_beat_t  beat_q[$];
    logic [9:0] addr_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         issued = 0;
    int         retired = 0;
    int         rrdy_mode = 0;
    logic [7:0] cur_id = 8'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [9:0] a);
        return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h9E37_79B1};
    endfunction

    // Synchronous array model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);
    end

    initial begin
        int ph;
        ph = 0;
        rrdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rrdy_mode)
                0:       rrdy = 1'b1;
                1:       rrdy = ((ph % 3) == 0);
                default: rrdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: array address order, R beat contents, stall stability, arrdy return.
    initial begin
        logic        stall_p;
        logic        want_arrdy;
        logic [63:0] h_data;
        logic        h_last;
        logic [1:0]  h_resp;
        exp_beat_t   e;
        logic [9:0]  ea;
        stall_p    = 1'b0;
        want_arrdy = 1'b0;
        h_data     = '0;
        h_last     = 1'b0;
        h_resp     = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_p    = 1'b0;
                want_arrdy = 1'b0;
            end else begin
                if (want_arrdy) begin
                    check_eq("arrdy_after_last", 64'(arrdy), 64'(1));
                    want_arrdy = 1'b0;
                end
                if (mem_rd_en) begin
                    issued++;
                    check_eq("issue_expected", 64'(addr_q.size() != 0), 64'(1));
                    if (addr_q.size() != 0) begin
                        ea = addr_q.pop_front();
                        check_eq("mem_addr", 64'(mem_rd_addr), 64'(ea));
                    end
                    check_eq("outstanding_le3", 64'((issued - retired) <= 3), 64'(1));
                end
                if (stall_p) begin
                    check_eq("stall_rvld", 64'(rvld), 64'(1));
                    check_eq("stall_rdata", rdata, h_data);
                    check_eq("stall_rlast", 64'(rlast), 64'(h_last));
                    check_eq("stall_rresp", 64'(rresp), 64'(h_resp));
                end
                if (rvld) begin
                    if (rrdy) begin
                        retired++;
                        check_eq("beat_expected", 64'(beat_q.size() != 0), 64'(1));
                        if (beat_q.size() != 0) begin
                            e = beat_q.pop_front();
                            check_eq("rdata", rdata, e.data);
                            check_eq("rlast", 64'(rlast), 64'(e.last));
                            check_eq("rresp", 64'(rresp), 64'(e.resp));
                            check_eq("rid", 64'(rid), 64'(cur_id));
                            if (beat_q.size() == 0) want_arrdy = 1'b1;
                        end
                    end
                    stall_p = !rrdy;
                    h_data  = rdata;
                    h_last  = rlast;
                    h_resp  = rresp;
                end else begin
                    stall_p = 1'b0;
                end
            end
        end
    end

    task automatic expect_req(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [2:0] str, input logic [7:0] num);
        int        base;
        int        a;
        bit        rerr;
        exp_beat_t e;
        base = int'(addr);
        for (int b = 0; b <= int'(num); b++) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = (base + ((burst == 2'b00) ? 0 : i)) & 'h3FF;
`ifdef AXI_RD_ADDR_CHK_EN
                rerr = (a >= int'(MEMW));
`else
                rerr = 1'b0;
`endif
                e.data = rerr ? 64'd0 : mem_word(10'(a));
                e.last = (i == int'(len));
                e.resp = (burst[1] || rerr) ? 2'b10 : 2'b00;
                beat_q.push_back(e);
                if (!rerr) addr_q.push_back(10'(a));
            end
            base = (base + ((int'(len) + 1) << str)) & 'h3FF;
        end
    endtask

    task automatic drive_ar(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] str, input logic [7:0] num);
        int n;
        cur_id = id;
        @(posedge clk);
        #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arstr = str; arnum = num;
        arsize = 3'd3; arvld = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arrdy && n < 100);
        check_eq("ar_accept", 64'(arrdy), 64'(1));
        @(posedge clk);
        #1;
        arvld = 1'b0;
    endtask

    task automatic run_req(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] str, input logic [7:0] num,
                           input int mode, input bit chk_lat);
        int lat;
        int n;
        bit done;
        rrdy_mode = mode;
        expect_req(addr, len, burst, str, num);
        drive_ar(id, addr, len, burst, str, num);
        // #1 after the handshake edge is still in cycle 1; count negedges up to first rvld.
        lat = 0;
        do begin
            if (lat > 0 || 1'b1) @(negedge clk);
            lat++;
        end while (!rvld && lat < 20);
        if (chk_lat) check_eq("first_beat_latency", 64'(lat), 64'(3));
        done = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = (beat_q.size() == 0) && (addr_q.size() == 0) && arrdy && !rvld;
        end
        check_eq("req_done", 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int n;
        rst_n = 1'b0;
        arvld = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
        arburst = '0; arstr = '0; arnum = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arrdy", 64'(arrdy), 64'(1));
        check_eq("rst_rvld", 64'(rvld), 64'(0));
        check_eq("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_rlast_rresp_rid", {rlast, rresp, rid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_arrdy", 64'(arrdy), 64'(1));

        run_req(8'h11, 10'h010, 8'd3, 2'b01, 3'd0, 8'd0, 0, 1'b1);
        run_req(8'h22, 10'h020, 8'd1, 2'b01, 3'd1, 8'd2, 0, 1'b1);
        run_req(8'h33, 10'h010, 8'd3, 2'b01, 3'd0, 8'd0, 1, 1'b1);
        run_req(8'h44, 10'h3FE, 8'd3, 2'b01, 3'd0, 8'd0, 0, 1'b0);
        run_req(8'h55, 10'h055, 8'd2, 2'b00, 3'd0, 8'd0, 1, 1'b0);
        run_req(8'h66, 10'h100, 8'd3, 2'b10, 3'd0, 8'd1, 0, 1'b0);
        run_req(8'h67, 10'h140, 8'd0, 2'b11, 3'd2, 8'd3, 2, 1'b0);
        run_req(8'h77, 10'h1FF, 8'd1, 2'b01, 3'd0, 8'd0, 0, 1'b0);
        run_req(8'h88, 10'h3F0, 8'd2, 2'b01, 3'd2, 8'd3, 2, 1'b0);
        run_req(8'h99, 10'h000, 8'd0, 2'b01, 3'd0, 8'd0, 0, 1'b1);

        // Reset in the middle of a 4-beat burst.
        rrdy_mode = 0;
        r0 = retired;
        expect_req(10'h200, 8'd3, 2'b01, 3'd0, 8'd0);
        drive_ar(8'hAA, 10'h200, 8'd3, 2'b01, 3'd0, 8'd0);
        n = 0;
        while (retired < r0 + 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_burst_reached", 64'(retired >= r0 + 1), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rvld", 64'(rvld), 64'(0));
        check_eq("midrst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        beat_q.delete();
        addr_q.delete();
        issued = 0;
        retired = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_midrst_arrdy", 64'(arrdy), 64'(1));
        check_eq("post_midrst_rvld", 64'(rvld), 64'(0));
        run_req(8'hBB, 10'h030, 8'd3, 2'b01, 3'd0, 8'd0, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
